regbank_read_arbiter: RTL and testbench

- Shares the single 32-entry x 32-bit register-bank read port among NREQ requesters using round-robin arbitration. Candidate requesters: fetch/decode, debug, trace.
- Drives the read-port select, captures the muxed read data one cycle later, and returns it to the winning requester with a one-hot response strobe.
- Sits between the requesters and the register bank read multiplexer. Fully pipelined: one grant per cycle.

---
 rtl/regbank_read_arbiter_pkg.sv | 8 +
 rtl/regbank_read_arbiter_if.sv | 17 +
 rtl/regbank_read_arbiter_rr_arbiter.sv | 44 ++++
 rtl/regbank_read_arbiter.sv | 76 +++++++
 tb/tb_regbank_read_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/regbank_read_arbiter_pkg.sv
// Shared register-bank widths and types for the read-port arbiter slice.
package regbank_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;
endpackage

// File: rtl/regbank_read_arbiter_if.sv
// Requester-side bundle: packed read requests, one-hot grants, one-hot responses with shared data.
interface regbank_read_arbiter_if
  import regbank_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;

  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/regbank_read_arbiter_rr_arbiter.sv
// Round-robin arbiter, combinational one-hot grant searching upward from ptr+1.
// Grant is zero while en is low or reset is high; ptr tracks the last granted index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] ptr
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] nxt;
  logic          found;
  int            j;

  always_comb begin
    gnt   = '0;
    nxt   = ptr;
    found = 1'b0;
    j     = 0;
    if (en && !reset) begin
      for (int i = 1; i <= N; i++) begin
        j = (int'(ptr) + i) % N;
        if (req[j] && !found) begin
          gnt[j] = 1'b1;
          nxt    = PW'(j);
          found  = 1'b1;
        end
      end
    end
  end

  // Starting at N-1 gives requester 0 first priority out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PW'(N - 1);
    end else if (found) begin
      ptr <= nxt;
    end
  end
endmodule

// File: rtl/regbank_read_arbiter.sv
// Round-robin share of the register-bank read port; response 2 cycles after grant, one grant per cycle.
// No response backpressure; hold only blocks new grants. Optional forwarding: REGBANK_ARB_BYPASS_EN.
module regbank_read_arbiter
  import regbank_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  regbank_read_arbiter_if.slave   bus,
  output logic [AW-1:0]           rd_sel,
  input  logic [DW-1:0]           rd_data
`ifdef REGBANK_ARB_BYPASS_EN
  ,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DW-1:0]           wr_data
`endif
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   s1_id;
  logic            s1_valid;
  logic [AW-1:0]   gaddr;
  logic [DW-1:0]   cap_data;
  logic [NREQ-1:0] resp_valid_q;
  logic [DW-1:0]   resp_data_q;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (~hold),
    .req   (bus.req_valid),
    .gnt   (gnt),
    .ptr   (ptr)
  );

  // The pointer moves to the winner on every grant, so while s1_valid is set it names the stage-1 owner.
  assign s1_id = ptr;

  always_comb begin
    gaddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gaddr = bus.req_addr[i*AW +: AW];
    end
  end

`ifdef REGBANK_ARB_BYPASS_EN
  assign cap_data = (wr_en && (wr_addr == rd_sel)) ? wr_data : rd_data;
`else
  assign cap_data = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel       <= '0;
      s1_valid     <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      s1_valid <= |gnt;
      if (|gnt) rd_sel <= gaddr;
      resp_valid_q <= s1_valid ? (NREQ'(1) << s1_id) : '0;
      if (s1_valid) resp_data_q <= cap_data;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_regbank_read_arbiter.sv
// Directed bench with a timestamped response scoreboard for regbank_read_arbiter.
module tb_regbank_read_arbiter;
  import regbank_pkg::*;

  typedef struct {
    int         cyc;
    logic [3:0] id;
    reg_data_t  data;
  } exp_t;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      hold = 1'b0;
  reg_addr_t rd_sel;
  reg_data_t rd_data;
  reg_data_t bank [32];
  int        cyc = 0;
  int        compared = 0;
  int        mismatched = 0;
  exp_t      sb [$];

`ifdef REGBANK_ARB_BYPASS_EN
  logic      wr_en = 1'b0;
  reg_addr_t wr_addr = '0;
  reg_data_t wr_data = '0;
`endif

  regbank_read_arbiter_if #(.NREQ(4)) bus ();

  regbank_read_arbiter #(.NREQ(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .bus     (bus.slave),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
`ifdef REGBANK_ARB_BYPASS_EN
    ,
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rd_data = bank[rd_sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; checks the combinational grant and queues the expected response.
  task automatic drive(input logic rst, input logic h, input logic [3:0] v, input logic [19:0] a,
                       input logic [3:0] exp_rdy, input logic push);
    int w;
    @(posedge clk);
    #1;
    reset = rst;
    hold = h;
    bus.req_valid = v;
    bus.req_addr = a;
    #1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (push && exp_rdy != 4'b0) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) w = i;
      sb.push_back('{cyc + 2, exp_rdy, bank[a[w*5 +: 5]]});
    end
  endtask

  // Monitor: pops on every response and flags any queued response whose cycle has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      compared++;
      mismatched++;
      $display("FAIL missing_resp: id %b due cycle %0d, still absent at cycle %0d", sb[0].id, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (bus.resp_valid !== 4'b0) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_resp at cycle %0d: got valid %b data %h, expected none", cyc, bus.resp_valid, bus.resp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.id !== bus.resp_valid || e.data !== bus.resp_data) begin
          mismatched++;
          $display("FAIL resp: got cycle %0d valid %b data %h, expected cycle %0d valid %b data %h",
                   cyc, bus.resp_valid, bus.resp_data, e.cyc, e.id, e.data);
        end
      end
    end
  end

  localparam logic [19:0] RR_ADDRS = {5'd4, 5'd3, 5'd2, 5'd1};

  initial begin
    logic [3:0] rr_exp [8];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 32; i++) bank[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    bank[1] = 32'h1111_0001;
    bank[2] = 32'h2222_0002;
    bank[3] = 32'h3333_0003;
    bank[4] = 32'h4444_0004;
    bank[7] = 32'hDEAD_BEEF;
    bank[9] = 32'h9999_0009;
    bus.req_valid = '0;
    bus.req_addr = '0;

    // Reset held with every requester asking
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'b1111, RR_ADDRS, 4'b0000, 1'b0);
      check("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
    end
    check("reset_rd_sel", 32'(rd_sel), 32'h0);
    check("reset_resp_data", bus.resp_data, 32'h0);

    // Round robin starting at requester 0 on release
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 4'b1111, RR_ADDRS, rr_exp[i], 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);

    // Single read of address 7 by requester 2
    drive(1'b0, 1'b0, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, 4'b0100, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    check("single_rd_sel", 32'(rd_sel), 32'd7);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    check("single_resp_data", bus.resp_data, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    check("resp_data_holds", bus.resp_data, 32'hDEAD_BEEF);

    // Hold blocks requester 1 for five cycles, then it wins immediately
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, 4'b0010, 1'b1);
    // Grant just before hold rises must still respond
    drive(1'b0, 1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd6}, 4'b0001, 1'b1);
    drive(1'b0, 1'b1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd6}, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);

    // Lone requester granted every cycle, including address 0
    drive(1'b0, 1'b0, 4'b1000, {5'd12, 15'h0}, 4'b1000, 1'b1);
    drive(1'b0, 1'b0, 4'b1000, {5'd0, 15'h0}, 4'b1000, 1'b1);
    drive(1'b0, 1'b0, 4'b1000, {5'd13, 15'h0}, 4'b1000, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);

    // Reset one cycle after a grant drops that response
    drive(1'b0, 1'b0, 4'b1000, {5'd20, 15'h0}, 4'b1000, 1'b0);
    drive(1'b1, 1'b0, 4'b1000, {5'd20, 15'h0}, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    check("midflight_resp_valid", 32'(bus.resp_valid), 32'h0);
    drive(1'b0, 1'b0, 4'b1111, RR_ADDRS, 4'b0001, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);

`ifdef REGBANK_ARB_BYPASS_EN
    // Write to the address being read forwards the write data
    drive(1'b0, 1'b0, 4'b0100, {5'd0, 5'd9, 10'h0}, 4'b0100, 1'b0);
    sb.push_back('{cyc + 2, 4'b0100, 32'h1234_5678});
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    wr_en = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h1234_5678;
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    wr_en = 1'b0;
    // Write to a different address leaves the bank value
    drive(1'b0, 1'b0, 4'b0100, {5'd0, 5'd9, 10'h0}, 4'b0100, 1'b0);
    sb.push_back('{cyc + 2, 4'b0100, 32'h9999_0009});
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    wr_en = 1'b1;
    wr_addr = 5'd10;
    wr_data = 32'h1234_5678;
    drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    wr_en = 1'b0;
`endif

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 4'b0000, 20'h0, 4'b0000, 1'b0);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
